// File: rtl/pwm_defs.sv
// Shared register map, CTRL bit positions and small helpers for the PWM stage.
package pwm_defs;

  localparam int unsigned ADR_W = 4;

  localparam logic [ADR_W-1:0] ADR_PERIOD   = 4'd0;
  localparam logic [ADR_W-1:0] ADR_CTRL     = 4'd1;
  localparam logic [ADR_W-1:0] ADR_COUNTER  = 4'd2;
  localparam logic [ADR_W-1:0] ADR_POLARITY = 4'd3;
  localparam logic [ADR_W-1:0] ADR_ON_BASE  = 4'd4;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_CENTER_BIT = 1;
  localparam int unsigned CTRL_RELOAD_BIT = 2;

  // Counter direction; only center mode ever counts down.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Stored CTRL bits; the reload bit is a strobe and is never kept.
  typedef struct packed {
    logic center;
    logic enable;
  } ctrl_t;

  // ON_TIME shadow address of channel ch.
  function automatic logic [ADR_W-1:0] on_time_adr(input int ch);
    return ADR_W'(ch + int'(ADR_ON_BASE));
  endfunction

endpackage

// File: rtl/pwm_multi_output_stage_channel.sv
// One PWM channel: on-time shadow/active pair, compare against the shared counter,
// polarity and the registered output.
module pwm_compare_channel
  import pwm_defs::*;
#(
  parameter int unsigned REG_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 on_we_i,
  input  logic [REG_WIDTH-1:0] data_i,
  input  logic                 reload_i,
  input  logic                 enable_i,
  input  logic                 polarity_i,
  input  logic [REG_WIDTH-1:0] count_i,
  output logic                 pwm_o
);

  logic [REG_WIDTH-1:0] on_shadow_q, on_shadow_d;
  logic [REG_WIDTH-1:0] on_act_q, on_act_d;
  logic                 pwm_q, pwm_d;
  logic                 raw_c;

  // Shadow capture, reload into the active copy, compare and polarity.
  always_comb begin
    on_shadow_d = on_shadow_q;
    on_act_d    = on_act_q;
    if (on_we_i) begin
      on_shadow_d = data_i;
    end
    if (reload_i) begin
      on_act_d = on_shadow_q;
    end
    raw_c = (count_i < on_act_q);
    pwm_d = enable_i ? (raw_c ^ polarity_i) : polarity_i;
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      on_shadow_q <= '0;
      on_act_q    <= '0;
      pwm_q       <= 1'b0;
    end else begin
      on_shadow_q <= on_shadow_d;
      on_act_q    <= on_act_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_output_stage.sv
// Multi-channel PWM: one shared edge/center counter with shadowed period, and
// CHANNELS compare channels with per-channel on-time and polarity.
module pwm_multi_output_stage
  import pwm_defs::*;
#(
  parameter int unsigned REG_WIDTH = 18,
  parameter int unsigned CHANNELS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [ADR_W-1:0]     adr,
  input  logic [REG_WIDTH-1:0] data,
  output logic [CHANNELS-1:0]  pwm_out
);

  logic [REG_WIDTH-1:0] cnt_q, cnt_d;
  dir_e                 dir_q, dir_d;
  logic [REG_WIDTH-1:0] period_shadow_q, period_shadow_d;
  logic [REG_WIDTH-1:0] period_act_q, period_act_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [CHANNELS-1:0]  polarity_q, polarity_d;

  logic                 wr_period_c, wr_ctrl_c, wr_counter_c, wr_polarity_c;
  logic                 force_reload_c;
  logic                 reload_c;
  logic [REG_WIDTH-1:0] count_next_c;
  dir_e                 count_dir_c;

  // Register write decode.
  always_comb begin
    wr_period_c    = sel && (adr == ADR_PERIOD);
    wr_ctrl_c      = sel && (adr == ADR_CTRL);
    wr_counter_c   = sel && (adr == ADR_COUNTER);
    wr_polarity_c  = sel && (adr == ADR_POLARITY);
    force_reload_c = wr_ctrl_c && data[CTRL_RELOAD_BIT];
  end

  // Value and direction the counter would take by normal counting this cycle.
  always_comb begin
    count_next_c = cnt_q;
    count_dir_c  = DIR_UP;
    if ((period_act_q == '0) && (cnt_q == '0)) begin
      count_next_c = '0;
    end else if (cnt_q > period_act_q) begin
      // Above the period (after a change): run up and wrap through all-ones.
      count_next_c = cnt_q + REG_WIDTH'(1);
    end else if (!ctrl_q.center) begin
      count_next_c = (cnt_q == period_act_q) ? '0 : cnt_q + REG_WIDTH'(1);
    end else if (cnt_q == period_act_q) begin
      // Peak: turn around; with a period of 1 this lands directly on 0.
      count_next_c = cnt_q - REG_WIDTH'(1);
      count_dir_c  = (count_next_c == '0) ? DIR_UP : DIR_DOWN;
    end else if ((dir_q == DIR_DOWN) && (cnt_q != '0)) begin
      count_next_c = cnt_q - REG_WIDTH'(1);
      count_dir_c  = (count_next_c == '0) ? DIR_UP : DIR_DOWN;
    end else begin
      count_next_c = cnt_q + REG_WIDTH'(1);
    end
  end

  // Next state of the shared controller and the reload strobe.
  always_comb begin
    cnt_d           = cnt_q;
    dir_d           = dir_q;
    period_shadow_d = period_shadow_q;
    period_act_d    = period_act_q;
    ctrl_d          = ctrl_q;
    polarity_d      = polarity_q;
    reload_c        = 1'b0;

    if (wr_period_c) begin
      period_shadow_d = data;
    end
    if (wr_ctrl_c) begin
      ctrl_d.enable = data[CTRL_ENABLE_BIT];
      ctrl_d.center = data[CTRL_CENTER_BIT];
    end
    if (wr_polarity_c) begin
      polarity_d = data[CHANNELS-1:0];
    end

    if (wr_counter_c) begin
      cnt_d = data;
      dir_d = DIR_UP;
    end else if (ctrl_q.enable) begin
      cnt_d = count_next_c;
      dir_d = count_dir_c;
    end else begin
      dir_d = DIR_UP;
    end

    // A counter write overrides counting, so its cycle is never a wrap reload.
    reload_c = !ctrl_q.enable
            || force_reload_c
            || (!wr_counter_c && (count_next_c == '0));
    if (reload_c) begin
      period_act_d = period_shadow_q;
    end
  end

  // Shared controller registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q           <= '0;
      dir_q           <= DIR_UP;
      period_shadow_q <= '0;
      period_act_q    <= '0;
      ctrl_q          <= '0;
      polarity_q      <= '0;
    end else begin
      cnt_q           <= cnt_d;
      dir_q           <= dir_d;
      period_shadow_q <= period_shadow_d;
      period_act_q    <= period_act_d;
      ctrl_q          <= ctrl_d;
      polarity_q      <= polarity_d;
    end
  end

  // Compare channels, each owning its ON_TIME address.
  for (genvar n = 0; n < int'(CHANNELS); n++) begin : g_ch
    localparam logic [ADR_W-1:0] ChAdr = on_time_adr(n);

    pwm_compare_channel #(
      .REG_WIDTH(REG_WIDTH)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .on_we_i    (sel && (adr == ChAdr)),
      .data_i     (data),
      .reload_i   (reload_c),
      .enable_i   (ctrl_q.enable),
      .polarity_i (polarity_q[n]),
      .count_i    (cnt_q),
      .pwm_o      (pwm_out[n])
    );
  end

endmodule

// File: tb/tb_pwm_multi_output_stage.sv
// Scoreboard bench for pwm_multi_output_stage: stimulus queues per-cycle expected
// outputs, a monitor compares them on the falling edge.
module tb_pwm_multi_output_stage;
  import pwm_defs::*;

  localparam int unsigned W  = 18;
  localparam int unsigned CH = 4;

  // Hand-derived output sequences.
  localparam logic [4:0] EDGE_PAT  = 5'b11000;     // PERIOD=4, ON=2
  localparam logic [7:0] DUTY5_PAT = 8'b11111000;  // PERIOD=7, ON=5
  localparam logic [7:0] DUTY3_PAT = 8'b11100000;  // PERIOD=7, ON=3
  localparam logic [7:0] FORCE_PAT = 8'b11111001;  // ON 3 -> 6 via force reload
  // Thermometer of counter value with ON = 1,2,3,4 on channels 0..3.
  localparam logic [3:0] CENTER_PAT [8] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000,
                                            4'b0000, 4'b1000, 4'b1100, 4'b1110};
  localparam logic [3:0] CWRITE_PAT [10] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000,
                                             4'b1100, 4'b1000, 4'b0000, 4'b1111, 4'b1110};
  localparam logic [3:0] OVF_PAT [5] = '{4'b0000, 4'b0000, 4'b1111, 4'b1110, 4'b1100};

  typedef struct {
    int            cyc;
    logic [CH-1:0] mask;
    logic [CH-1:0] val;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel;
  logic [3:0]    adr;
  logic [W-1:0]  data;
  logic [CH-1:0] pwm_out;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  pwm_multi_output_stage #(
    .REG_WIDTH(W),
    .CHANNELS (CH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .adr     (adr),
    .data    (data),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
      end else if ((pwm_out & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("FAIL %s cycle %0d: pwm_out=%b expected %b (mask %b)", e.name, cyc, pwm_out, e.val, e.mask);
      end
    end
  end

  task automatic exp_at(input int c, input logic [CH-1:0] m, input logic [CH-1:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    sel  = 1'b1;
    adr  = a;
    data = d;
    @(negedge clk);
    sel  = 1'b0;
    adr  = '0;
    data = '0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations still pending at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
  endtask

  function automatic logic [3:0] on_adr(input int n);
    return 4'(int'(ADR_ON_BASE) + n);
  endfunction

  initial begin : stim
    int q;
    int r;
    reset = 1'b1;
    sel   = 1'b0;
    adr   = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q = cyc;
    for (int k = 1; k <= 3; k++) exp_at(q + k, 4'hF, 4'h0, "after_reset");
    drain();

    // Edge mode, PERIOD=4, ON0=2.
    wr(ADR_PERIOD, W'(4));
    wr(on_adr(0), W'(2));
    q = cyc;
    exp_at(q + 1, 4'hF, 4'h0, "edge_pre_enable");
    for (int k = 0; k < 15; k++) exp_at(q + 2 + k, 4'hF, {3'b000, EDGE_PAT[4 - (k % 5)]}, "edge");
    wr(ADR_CTRL, W'(1));
    drain();

    // Center mode, PERIOD=4, thermometer on-times.
    do_reset();
    wr(ADR_PERIOD, W'(4));
    for (int n = 0; n < 4; n++) wr(on_adr(n), W'(n + 1));
    q = cyc;
    exp_at(q + 1, 4'hF, 4'h0, "center_pre_enable");
    for (int k = 0; k < 16; k++) exp_at(q + 2 + k, 4'hF, CENTER_PAT[k % 8], "center");
    wr(ADR_CTRL, W'(3));
    drain();

    // Shadow update at wrap, then a forced reload mid-period.
    do_reset();
    wr(ADR_PERIOD, W'(7));
    wr(on_adr(0), W'(5));
    q = cyc;
    for (int k = 0; k < 8; k++) exp_at(q + 2 + k, 4'h1, {3'b000, DUTY5_PAT[7 - k]}, "shadow_old_duty");
    for (int k = 0; k < 8; k++) exp_at(q + 10 + k, 4'h1, {3'b000, DUTY3_PAT[7 - k]}, "shadow_new_duty");
    for (int k = 0; k < 8; k++) exp_at(q + 19 + k, 4'h1, {3'b000, FORCE_PAT[7 - k]}, "force_reload");
    wr(ADR_CTRL, W'(1));
    wait_until(q + 2);
    wr(on_adr(0), W'(3));
    wait_until(q + 18);
    wr(on_adr(0), W'(6));
    wr(ADR_CTRL, W'(5));
    drain();

    // Polarity while disabled, then enabled with ON1=0.
    do_reset();
    q = cyc;
    for (int k = 2; k <= 4; k++) exp_at(q + k, 4'hF, 4'b0101, "polarity_disabled");
    wr(ADR_POLARITY, W'(5));
    wr(ADR_PERIOD, W'(4));
    wr(on_adr(0), W'(2));
    wr(on_adr(1), W'(0));
    q = cyc;
    exp_at(q + 1, 4'hF, 4'b0101, "polarity_disabled");
    for (int k = 0; k < 10; k++) exp_at(q + 2 + k, 4'hF, {3'b010, ~EDGE_PAT[4 - (k % 5)]}, "polarity_enabled");
    wr(ADR_CTRL, W'(1));
    drain();

    // ON0 = PERIOD+1 is constantly active.
    do_reset();
    wr(ADR_PERIOD, W'(4));
    wr(on_adr(0), W'(5));
    q = cyc;
    for (int k = 0; k < 10; k++) exp_at(q + 2 + k, 4'h1, 4'h1, "on_above_period");
    wr(ADR_CTRL, W'(1));
    drain();

    // PERIOD=0 with ON0=1, edge then center mode.
    do_reset();
    wr(ADR_PERIOD, W'(0));
    wr(on_adr(0), W'(1));
    q = cyc;
    for (int k = 0; k < 14; k++) exp_at(q + 2 + k, 4'h1, 4'h1, "period_zero");
    wr(ADR_CTRL, W'(1));
    wait_until(q + 6);
    wr(ADR_CTRL, W'(3));
    drain();

    // COUNTER write on the wrap cycle, then a load near all-ones.
    do_reset();
    wr(ADR_PERIOD, W'(4));
    for (int n = 0; n < 4; n++) wr(on_adr(n), W'(n + 1));
    q = cyc;
    for (int k = 0; k < 10; k++) exp_at(q + 2 + k, 4'hF, CWRITE_PAT[k], "counter_write_at_wrap");
    wr(ADR_CTRL, W'(1));
    wait_until(q + 5);
    wr(ADR_COUNTER, W'(2));
    wait_until(q + 12);
    r = cyc;
    for (int k = 0; k < 5; k++) exp_at(r + 2 + k, 4'hF, OVF_PAT[k], "counter_overflow_wrap");
    wr(ADR_COUNTER, W'(18'h3FFFE));
    wait_until(r + 7);

    // Reset mid-period with a simultaneous POLARITY write that must be dropped.
    r = cyc;
    for (int k = 1; k <= 6; k++) exp_at(r + k, 4'hF, 4'h0, "reset_priority");
    reset = 1'b1;
    sel   = 1'b1;
    adr   = ADR_POLARITY;
    data  = W'(4'hF);
    @(negedge clk);
    reset = 1'b0;
    sel   = 1'b0;
    adr   = '0;
    data  = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_multi_output_stage.md
PWM_MULTI_OUTPUT_STAGE -- requirements
Module: pwm_multi_output_stage

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 18, giving the width of the counter, period and on-time registers.
REQ-002 The block SHALL have parameter CHANNELS, default 4, range 1..12, giving the number of PWM outputs sharing one counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port sel, input, 1 bit: register write strobe, one write per cycle.
REQ-006 The block SHALL have port adr, input, 4 bits: register address.
REQ-007 The block SHALL have port data, input, REG_WIDTH bits: write data.
REQ-008 The block SHALL have port pwm_out, output, CHANNELS bits: registered PWM outputs.

Function
REQ-009 Address map SHALL be: 0 PERIOD shadow; 1 CTRL (bit0 enable, bit1 center mode, bit2 force reload); 2 COUNTER; 3 POLARITY (bit n for channel n); 4+n ON_TIME shadow for channel n. Writes to other addresses SHALL be ignored.
REQ-010 PERIOD and ON_TIME writes SHALL go to shadow registers only; active copies SHALL load from shadows on a reload cycle.
REQ-011 Reload cycles SHALL be: every cycle while enable=0; the cycle the counter's next value is 0 by normal counting; and the cycle CTRL is written with bit2=1. Bit2 SHALL be self-clearing and never stored.
REQ-012 Edge mode (bit1=0): counter SHALL count 0..P_act, then wrap to 0, giving period P_act+1 cycles.
REQ-013 Center mode (bit1=1): counter SHALL count up 0..P_act, then down P_act-1..1, then 0, giving period 2*P_act cycles. Direction SHALL flip on reaching P_act (up) and 0 (down).
REQ-014 P_act=0 SHALL hold the counter at 0 in both modes, with direction up.
REQ-015 While enable=0 the counter SHALL hold its value and direction SHALL be up.
REQ-016 A COUNTER write SHALL load data, set direction up, and take precedence over counting that cycle; it is not a reload cycle.
REQ-017 Raw channel state SHALL be (counter < ON_act[n]) as an unsigned compare. ON_act=0 gives constantly inactive; ON_act>P_act gives constantly active.
REQ-018 pwm_out[n] SHALL be registered: raw[n] XOR POLARITY[n] when enabled, else POLARITY[n]. Latency from the counter value to the output is 1 cycle.
REQ-019 A CTRL mode change SHALL take effect the next cycle without resetting the counter. A counter above P_act after a change SHALL continue counting up and wrap at all-ones to 0; wrap-around is modulo 2^REG_WIDTH.

Reset
REQ-020 Reset SHALL clear counter, direction (up), shadow and active PERIOD/ON_TIME, CTRL, POLARITY, and pwm_out to all zeros.
REQ-021 Reset SHALL take priority over a simultaneous sel write, and SHALL apply mid-period with no pending reload retained.

Structure
REQ-022 Address constants (ADR_PERIOD, ADR_CTRL, ADR_COUNTER, ADR_POLARITY, ADR_ON_BASE) and CTRL bit indices SHALL live in a shared package/include, pwm_defs.
REQ-023 The block SHALL contain one shared counter/mode controller and CHANNELS instances of sub-module pwm_compare_channel: on-time shadow, active register, compare, and polarity output register.

Verification
REQ-024 Edge mode: PERIOD=4, ON0=2, enable=1 -> pwm_out[0] SHALL be 11000 repeating (5-cycle period), starting 1 cycle after the counter is 0.
REQ-025 Center mode: PERIOD=4, ON0=1, CTRL=3 -> counter sequence 0,1,2,3,4,3,2,1 repeating; pwm_out[0] SHALL be high exactly one cycle in 8.
REQ-026 Shadow update: ON0 written 3 while the counter is 1 (PERIOD=7, ON0 was 5) -> duty SHALL stay 5/8 until the counter wraps, then become 3/8; a CTRL write with bit2=1 SHALL instead apply it next cycle.
REQ-027 Polarity/disable: POLARITY=0b0101, enable=0 -> pwm_out=0b0101 constant; ON1=0 with enable=1 -> bit1 SHALL be constantly 0.
REQ-028 Boundaries: ON0=PERIOD+1 -> constant 1; PERIOD=0 with ON0=1 -> constant 1; COUNTER write of 2 in the same cycle as a wrap -> the next counter value SHALL be 2.
REQ-029 Reset asserted mid-period with sel=1 -> on the next cycle all registers are 0 and pwm_out=0.
